// File: rtl/ps2_keyboard_decoder.sv
// PS/2 Set-2 keyboard receiver: synchronizes and filters the PS/2 pins, frames 11-bit bytes,
// tracks E0/F0 prefixes and shift state, and presents the last make code with its ASCII value.
module ps2_keyboard_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk_async,
    input  logic       ps2_data_async,
    output logic [7:0] scan_code,
    output logic [7:0] ascii_code,
    output logic       key_pressed,
    output logic       key_released
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic          fall_bit;
    logic [10:0]   shreg;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic          frame_done;
    logic          ext_flag;
    logic          brk_flag;
    logic          lshift;
    logic          rshift;
    logic [7:0]    frame_byte;
    logic          frame_ok;

    function automatic logic [7:0] map_ascii(input logic [7:0] code, input logic ext,
                                             input logic shift);
        logic [7:0] letter;
        logic [7:0] other;
        letter = 8'h00;
        other  = 8'h00;
        case (code)
            8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
            8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
            8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
            8'h45: other = 8'h30;   8'h16: other = 8'h31;   8'h1E: other = 8'h32;
            8'h26: other = 8'h33;   8'h25: other = 8'h34;   8'h2E: other = 8'h35;
            8'h36: other = 8'h36;   8'h3D: other = 8'h37;   8'h3E: other = 8'h38;
            8'h46: other = 8'h39;
            8'h29: other = 8'h20;   8'h5A: other = 8'h0D;   8'h66: other = 8'h08;
            8'h0D: other = 8'h09;   8'h76: other = 8'h1B;
            default: ;
        endcase
        if (ext)
            return 8'h00;
        if (letter != 8'h00)
            return shift ? (letter - 8'h20) : letter;
        return other;
    endfunction

    // Pins idle high, so the synchronizers and filter come out of reset at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_async};
            data_sync <= {data_sync[0], ps2_data_async};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
            fall_bit <= 1'b1;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                fall     <= clk_filt;
                fall_bit <= data_sync[1];
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Frame shifter; bits arrive LSB first so the start bit ends up in shreg[0].
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (fall) begin
                shreg  <= {fall_bit, shreg[10:1]};
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

    assign frame_byte = shreg[8:1];
    assign frame_ok   = !shreg[0] && shreg[10] && (^shreg[9:1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_code    <= '0;
            ascii_code   <= '0;
            key_pressed  <= 1'b0;
            key_released <= 1'b0;
            ext_flag     <= 1'b0;
            brk_flag     <= 1'b0;
            lshift       <= 1'b0;
            rshift       <= 1'b0;
        end else begin
            key_released <= 1'b0;
            if (frame_done && frame_ok) begin
                if (frame_byte == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (frame_byte == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                    if (!ext_flag && frame_byte == 8'h12) begin
                        lshift <= !brk_flag;
                    end else if (!ext_flag && frame_byte == 8'h59) begin
                        rshift <= !brk_flag;
                    end else if (!brk_flag) begin
                        scan_code   <= frame_byte;
                        ascii_code  <= map_ascii(frame_byte, ext_flag, lshift | rshift);
                        key_pressed <= 1'b1;
                    end else begin
                        key_released <= 1'b1;
                        if (frame_byte == scan_code)
                            key_pressed <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Directed bench for ps2_keyboard_decoder: bit-bangs PS/2 frames on the async pins and
// checks scan/ASCII/press/release behaviour against hand-computed values.
module tb_ps2_keyboard_decoder;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF           = 30;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk_async = 1'b1;
    logic       ps2_data_async = 1'b1;
    logic [7:0] scan_code;
    logic [7:0] ascii_code;
    logic       key_pressed;
    logic       key_released;

    int vectors = 0;
    int errors  = 0;
    int rel_total = 0;
    int rel_base;

    ps2_keyboard_decoder #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ps2_clk_async (ps2_clk_async),
        .ps2_data_async(ps2_data_async),
        .scan_code     (scan_code),
        .ascii_code    (ascii_code),
        .key_pressed   (key_pressed),
        .key_released  (key_released)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_released === 1'b1)
            rel_total++;
    end

    // driver tasks
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data_async = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk_async = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk_async = 1'b1;
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
        logic par;
        par = bad_par ? (^b) : ~(^b);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0);
        send_bits(make_frame(b, bad_par), 11);
        ps2_data_async = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        vectors++; if (scan_code !== 8'h00) begin errors++; $display("FAIL reset_scan: got %h want 00", scan_code); end
        vectors++; if (ascii_code !== 8'h00) begin errors++; $display("FAIL reset_ascii: got %h want 00", ascii_code); end
        vectors++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL reset_pressed: got %b want 0", key_pressed); end
        vectors++; if (key_released !== 1'b0) begin errors++; $display("FAIL reset_released: got %b want 0", key_released); end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_make_break();
        send_frame(8'h1C);
        vectors++; if (scan_code !== 8'h1C) begin errors++; $display("FAIL mb_scan: got %h want 1c", scan_code); end
        vectors++; if (ascii_code !== 8'h61) begin errors++; $display("FAIL mb_ascii: got %h want 61", ascii_code); end
        vectors++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL mb_pressed: got %b want 1", key_pressed); end
        rel_base = rel_total;
        send_frame(8'hF0);
        vectors++; if (rel_total - rel_base !== 0) begin errors++; $display("FAIL mb_f0_no_pulse: got %0d want 0", rel_total - rel_base); end
        send_frame(8'h1C);
        vectors++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL mb_break_pressed: got %b want 0", key_pressed); end
        vectors++; if (rel_total - rel_base !== 1) begin errors++; $display("FAIL mb_release_pulse: got %0d cycles want 1", rel_total - rel_base); end
        vectors++; if (ascii_code !== 8'h61) begin errors++; $display("FAIL mb_ascii_hold: got %h want 61", ascii_code); end
    endtask

    task automatic test_shift();
        send_frame(8'h12);
        vectors++; if (ascii_code !== 8'h61 || key_pressed !== 1'b0) begin errors++; $display("FAIL shift_no_change: got %h/%b want 61/0", ascii_code, key_pressed); end
        send_frame(8'h1C);
        vectors++; if (ascii_code !== 8'h41) begin errors++; $display("FAIL shift_upper: got %h want 41", ascii_code); end
        send_frame(8'hF0); send_frame(8'h1C);
        send_frame(8'hF0); send_frame(8'h12);
        send_frame(8'h1C);
        vectors++; if (ascii_code !== 8'h61) begin errors++; $display("FAIL shift_released_lower: got %h want 61", ascii_code); end
        send_frame(8'hF0); send_frame(8'h1C);
    endtask

    task automatic test_parity();
        send_frame(8'h1C, 1'b1);
        vectors++; if (key_pressed !== 1'b0 || scan_code !== 8'h1C) begin errors++; $display("FAIL parity_dropped: got %h/%b want 1c/0", scan_code, key_pressed); end
        send_frame(8'h32);
        vectors++; if (scan_code !== 8'h32) begin errors++; $display("FAIL parity_next_scan: got %h want 32", scan_code); end
        vectors++; if (ascii_code !== 8'h62) begin errors++; $display("FAIL parity_next_ascii: got %h want 62", ascii_code); end
        send_frame(8'hF0); send_frame(8'h32);
    endtask

    task automatic test_extended();
        send_frame(8'hE0); send_frame(8'h75);
        vectors++; if (scan_code !== 8'h75) begin errors++; $display("FAIL ext_scan: got %h want 75", scan_code); end
        vectors++; if (ascii_code !== 8'h00) begin errors++; $display("FAIL ext_ascii: got %h want 00", ascii_code); end
        vectors++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL ext_pressed: got %b want 1", key_pressed); end
        rel_base = rel_total;
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
        vectors++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL ext_break: got %b want 0", key_pressed); end
        vectors++; if (rel_total - rel_base !== 1) begin errors++; $display("FAIL ext_release_pulse: got %0d want 1", rel_total - rel_base); end
    endtask

    task automatic test_timeout();
        send_bits(make_frame(8'h1C, 1'b0), 4);
        ps2_data_async = 1'b1;
        repeat (TIMEOUT_CYCLES + 300) @(negedge clk);
        send_frame(8'h45);
        vectors++; if (scan_code !== 8'h45) begin errors++; $display("FAIL timeout_scan: got %h want 45", scan_code); end
        vectors++; if (ascii_code !== 8'h30) begin errors++; $display("FAIL timeout_ascii: got %h want 30", ascii_code); end
        send_frame(8'hF0); send_frame(8'h45);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h1C); send_frame(8'h32);
        rel_base = rel_total;
        send_frame(8'hF0); send_frame(8'h1C);
        vectors++; if (key_pressed !== 1'b1) begin errors++; $display("FAIL overlap_still_pressed: got %b want 1", key_pressed); end
        vectors++; if (rel_total - rel_base !== 1) begin errors++; $display("FAIL overlap_pulse: got %0d want 1", rel_total - rel_base); end
        vectors++; if (scan_code !== 8'h32 || ascii_code !== 8'h62) begin errors++; $display("FAIL overlap_hold: got %h/%h want 32/62", scan_code, ascii_code); end
        send_frame(8'hF0); send_frame(8'h32);
        vectors++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL overlap_final: got %b want 0", key_pressed); end
    endtask

    task automatic test_maps();
        send_frame(8'h59);
        send_frame(8'h16);
        vectors++; if (ascii_code !== 8'h31) begin errors++; $display("FAIL map_digit_shift: got %h want 31", ascii_code); end
        send_frame(8'h1A);
        vectors++; if (ascii_code !== 8'h5A) begin errors++; $display("FAIL map_rshift_upper: got %h want 5a", ascii_code); end
        send_frame(8'h29);
        vectors++; if (ascii_code !== 8'h20) begin errors++; $display("FAIL map_space: got %h want 20", ascii_code); end
        send_frame(8'hF0); send_frame(8'h59);
        send_frame(8'h5A);
        vectors++; if (ascii_code !== 8'h0D) begin errors++; $display("FAIL map_enter: got %h want 0d", ascii_code); end
        send_frame(8'h05);
        vectors++; if (scan_code !== 8'h05 || ascii_code !== 8'h00) begin errors++; $display("FAIL map_unmapped: got %h/%h want 05/00", scan_code, ascii_code); end
        send_frame(8'hE0); send_frame(8'h12);
        vectors++; if (scan_code !== 8'h12 || ascii_code !== 8'h00) begin errors++; $display("FAIL map_ext_12: got %h/%h want 12/00", scan_code, ascii_code); end
        send_frame(8'h1A);
        vectors++; if (ascii_code !== 8'h7A) begin errors++; $display("FAIL map_ext12_not_shift: got %h want 7a", ascii_code); end
    endtask

    task automatic test_glitch();
        for (int g = 1; g <= 7; g += 2) begin
            ps2_clk_async = 1'b0;
            repeat (g) @(negedge clk);
            ps2_clk_async = 1'b1;
            repeat (20) @(negedge clk);
        end
        vectors++; if (scan_code !== 8'h1A || ascii_code !== 8'h7A) begin errors++; $display("FAIL glitch_idle: got %h/%h want 1a/7a", scan_code, ascii_code); end
        send_frame(8'h2B);
        vectors++; if (scan_code !== 8'h2B || ascii_code !== 8'h66) begin errors++; $display("FAIL glitch_next_frame: got %h/%h want 2b/66", scan_code, ascii_code); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h12);
        send_bits(make_frame(8'h32, 1'b0), 5);
        ps2_data_async = 1'b0;
        ps2_clk_async  = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++; if (scan_code !== 8'h00) begin errors++; $display("FAIL midrst_scan: got %h want 00", scan_code); end
        vectors++; if (ascii_code !== 8'h00) begin errors++; $display("FAIL midrst_ascii: got %h want 00", ascii_code); end
        vectors++; if (key_pressed !== 1'b0 || key_released !== 1'b0) begin errors++; $display("FAIL midrst_flags: got %b/%b want 0/0", key_pressed, key_released); end
        ps2_clk_async  = 1'b1;
        ps2_data_async = 1'b1;
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h1C);
        vectors++; if (scan_code !== 8'h1C || ascii_code !== 8'h61 || key_pressed !== 1'b1) begin errors++; $display("FAIL midrst_next_frame: got %h/%h/%b want 1c/61/1", scan_code, ascii_code, key_pressed); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_shift();
        test_parity();
        test_extended();
        test_timeout();
        test_back_to_back();
        test_maps();
        test_glitch();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
